// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame scheduler for the tilt-matrix datapath.
// Every frame it runs IMU sample -> physics step -> WS2812 refresh. Each stage
// is kicked with a 1-cycle start pulse and ends on its done strobe or on a
// stage timeout. A period counter keeps frames FRAME_CYCLES apart.
//
// Ports
//   clk, rst_n         clock, async active-low reset
//   i_enable           run frames while high (current frame always completes)
//   o_imu_start   / i_imu_done    IMU stage handshake
//   o_phys_start  / i_phys_done   physics stage handshake
//   o_led_start   / i_led_done    LED refresh stage handshake
//   o_frame_tick       1-cycle pulse after the LED stage ends
//   o_busy             high outside IDLE
//   o_err_timeout[2:0] sticky stage timeout flags {led,phys,imu}
//   o_err_overrun      sticky: frame work exceeded the frame period
//   i_err_clr          clears sticky flags (a flag set in the same cycle wins)
//   o_frame_count[7:0] completed frames, wraps modulo 256
//   o_state_dbg[2:0]   state encoding IDLE=0 IMU=1 PHYS=2 LED=3 WAIT=4
module frame_sequencer #(
  parameter int FRAME_CYCLES   = 1_000_000,
  parameter int TIMEOUT_CYCLES = 65_535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_enable,
  output logic       o_imu_start,
  input  logic       i_imu_done,
  output logic       o_phys_start,
  input  logic       i_phys_done,
  output logic       o_led_start,
  input  logic       i_led_done,
  output logic       o_frame_tick,
  output logic       o_busy,
  output logic [2:0] o_err_timeout,
  output logic       o_err_overrun,
  input  logic       i_err_clr,
  output logic [7:0] o_frame_count,
  output logic [2:0] o_state_dbg
);

  localparam int PW = $clog2(FRAME_CYCLES);
  localparam int SW = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] PER_MAX = PW'(FRAME_CYCLES - 1);
  localparam logic [SW-1:0] STG_MAX = SW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IMU  = 3'd1,
    S_PHYS = 3'd2,
    S_LED  = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_per;
  logic [SW-1:0] r_stg;
  logic          r_imu_start, r_phys_start, r_led_start, r_frame_tick;
  logic [2:0]    r_err_tmo;
  logic          r_err_ovr;
  logic [7:0]    r_frame_cnt;

  logic [2:0] w_stage;     // one-hot {led,phys,imu} of the active stage
  logic       w_first, w_done_ok, w_tmo, w_adv, w_per_sat, w_ovr_set;
  logic [2:0] w_tmo_set;

  always_comb begin
    w_stage = 3'b000;
    case (r_state)
      S_IMU:   w_stage = 3'b001;
      S_PHYS:  w_stage = 3'b010;
      S_LED:   w_stage = 3'b100;
      default: w_stage = 3'b000;
    endcase
  end

  // Start pulses are high exactly in a stage's first cycle, so they double as
  // the "ignore done in the start cycle" qualifier.
  assign w_first   = r_imu_start | r_phys_start | r_led_start;
  assign w_done_ok = |(w_stage & {i_led_done, i_phys_done, i_imu_done}) & ~w_first;
  assign w_tmo     = (|w_stage) & (r_stg == STG_MAX) & ~w_done_ok;
  assign w_adv     = w_done_ok | w_tmo;
  assign w_per_sat = (r_per == PER_MAX);
  assign w_tmo_set = w_stage & {3{w_tmo}};
  assign w_ovr_set = (r_state == S_LED) & w_adv & w_per_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_per        <= '0;
      r_stg        <= '0;
      r_imu_start  <= 1'b0;
      r_phys_start <= 1'b0;
      r_led_start  <= 1'b0;
      r_frame_tick <= 1'b0;
      r_err_tmo    <= '0;
      r_err_ovr    <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_imu_start  <= 1'b0;
      r_phys_start <= 1'b0;
      r_led_start  <= 1'b0;
      r_frame_tick <= 1'b0;
      r_stg        <= r_stg + 1'b1;
      r_per        <= w_per_sat ? r_per : r_per + 1'b1;

      // Set beats clear for flags raised in the same cycle as i_err_clr.
      r_err_tmo <= (r_err_tmo & {3{~i_err_clr}}) | w_tmo_set;
      r_err_ovr <= (r_err_ovr & ~i_err_clr) | w_ovr_set;

      case (r_state)
        S_IDLE: begin
          r_per <= '0;
          if (i_enable) begin
            r_state     <= S_IMU;
            r_imu_start <= 1'b1;
            r_stg       <= '0;
          end
        end
        S_IMU: if (w_adv) begin
          r_state      <= S_PHYS;
          r_phys_start <= 1'b1;
          r_stg        <= '0;
        end
        S_PHYS: if (w_adv) begin
          r_state     <= S_LED;
          r_led_start <= 1'b1;
          r_stg       <= '0;
        end
        S_LED: if (w_adv) begin
          r_state      <= S_WAIT;
          r_frame_tick <= 1'b1;
          r_frame_cnt  <= r_frame_cnt + 8'd1;
        end
        S_WAIT: if (w_per_sat) begin
          if (i_enable) begin
            r_state     <= S_IMU;
            r_imu_start <= 1'b1;
            r_stg       <= '0;
            r_per       <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_imu_start   = r_imu_start;
  assign o_phys_start  = r_phys_start;
  assign o_led_start   = r_led_start;
  assign o_frame_tick  = r_frame_tick;
  assign o_busy        = (r_state != S_IDLE);
  assign o_err_timeout = r_err_tmo;
  assign o_err_overrun = r_err_ovr;
  assign o_frame_count = r_frame_cnt;
  assign o_state_dbg   = r_state;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer with FRAME_CYCLES=20, TIMEOUT_CYCLES=8.
// Expected output events (start pulses / frame ticks with cycle numbers and
// flag snapshots) are queued by the stimulus; a negedge monitor pops them.
module tb_frame_sequencer;

  localparam int FC = 20;
  localparam int TC = 8;

  logic       clk = 1'b0;
  logic       rst_n, enable, err_clr;
  logic       imu_start, phys_start, led_start, frame_tick, busy, err_overrun;
  logic       imu_done, phys_done, led_done;
  logic [2:0] err_timeout, state_dbg;
  logic [7:0] frame_count;

  frame_sequencer #(.FRAME_CYCLES(FC), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(enable),
    .o_imu_start(imu_start), .i_imu_done(imu_done),
    .o_phys_start(phys_start), .i_phys_done(phys_done),
    .o_led_start(led_start), .i_led_done(led_done),
    .o_frame_tick(frame_tick), .o_busy(busy),
    .o_err_timeout(err_timeout), .o_err_overrun(err_overrun),
    .i_err_clr(err_clr), .o_frame_count(frame_count), .o_state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- done responder ----------------
  // lat[s]: done arrives lat cycles after the start pulse (0 = same cycle,
  // -1 = never). inj lets the stimulus drive stray strobes.
  int         lat[3];
  int         rem[3];
  logic [2:0] rsp_done = 3'b000;
  logic [2:0] inj      = 3'b000;
  logic [2:0] starts;

  assign starts    = {led_start, phys_start, imu_start};
  assign imu_done  = rsp_done[0] | inj[0];
  assign phys_done = rsp_done[1] | inj[1];
  assign led_done  = rsp_done[2] | inj[2];

  initial begin
    for (int s = 0; s < 3; s++) rem[s] = -1;
    forever begin
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) begin
        rsp_done[s] = 1'b0;
        if (starts[s]) rem[s] = lat[s];
        else if (rem[s] > 0) rem[s] = rem[s] - 1;
        if (rem[s] == 0) begin
          rsp_done[s] = 1'b1;
          rem[s] = -1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  // kind: 1=imu_start 2=phys_start 3=led_start 4=frame_tick; the state the
  // DUT must show during that event has the same encoding.
  typedef struct {
    int         kind;
    int         cyc;
    logic [2:0] err;
    logic       ovr;
    logic [7:0] fcnt;
  } ev_t;

  ev_t exp_q[$];
  int  ev_idx = 0;

  task automatic push(input int kind, input int at, input logic [2:0] err,
                      input logic ovr, input int fcnt);
    ev_t e;
    e.kind = kind; e.cyc = at; e.err = err; e.ovr = ovr; e.fcnt = 8'(fcnt);
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    n_cmp++;
    ev_idx++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event kind=%0d at cyc=%0d, none expected", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.err != err_timeout ||
          e.ovr != err_overrun || e.fcnt != frame_count ||
          state_dbg != 3'(kind) || busy !== 1'b1) begin
        n_err++;
        $display("FAIL event_%0d got kind=%0d cyc=%0d err=%b ovr=%b fcnt=%0d st=%0d busy=%b need kind=%0d cyc=%0d err=%b ovr=%b fcnt=%0d st=%0d busy=1",
                 ev_idx, kind, cyc, err_timeout, err_overrun, frame_count, state_dbg, busy,
                 e.kind, e.cyc, e.err, e.ovr, e.fcnt, e.kind);
      end
    end
  endtask

  logic [3:0] mon_hits;
  always @(negedge clk) begin
    mon_hits = {frame_tick, led_start, phys_start, imu_start};
    for (int k = 0; k < 4; k++)
      if (mon_hits[k] === 1'b1) check_ev(k + 1);
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input int got, input int need);
    n_cmp++;
    if (got != need) begin
      n_err++;
      $display("FAIL %s got=%0d need=%0d", name, got, need);
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_imu_start"},  int'(imu_start),   0);
    chk({tag, "_phys_start"}, int'(phys_start),  0);
    chk({tag, "_led_start"},  int'(led_start),   0);
    chk({tag, "_frame_tick"}, int'(frame_tick),  0);
    chk({tag, "_busy"},       int'(busy),        0);
    chk({tag, "_err_tmo"},    int'(err_timeout), 0);
    chk({tag, "_err_ovr"},    int'(err_overrun), 0);
    chk({tag, "_fcnt"},       int'(frame_count), 0);
    chk({tag, "_state"},      int'(state_dbg),   0);
  endtask

  initial begin
    int b, c, d;
    rst_n = 1'b0; enable = 1'b0; err_clr = 1'b0;
    for (int s = 0; s < 3; s++) lat[s] = 3;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_enable", int'(state_dbg), 0);

    b = cyc;
    c = b + 45;
    d = c + 41;
    // normal frames, stages end 3 cycles after start; enable drops in frame 2
    push(1, b+1,  3'b000, 0, 0); push(2, b+5,  3'b000, 0, 0);
    push(3, b+9,  3'b000, 0, 0); push(4, b+13, 3'b000, 0, 1);
    push(1, b+21, 3'b000, 0, 1); push(2, b+25, 3'b000, 0, 1);
    push(3, b+29, 3'b000, 0, 1); push(4, b+33, 3'b000, 0, 2);
    // restart from IDLE, physics timeout, then err_clr
    push(1, c+1,  3'b000, 0, 2); push(2, c+5,  3'b000, 0, 2);
    push(3, c+13, 3'b010, 0, 2); push(4, c+17, 3'b010, 0, 3);
    push(1, c+21, 3'b010, 0, 3); push(2, c+25, 3'b000, 0, 3);
    push(3, c+29, 3'b000, 0, 3); push(4, c+33, 3'b000, 0, 4);
    // overrun frame (7-cycle stages), WAIT lasts one cycle
    push(1, d,    3'b000, 0, 4); push(2, d+7,  3'b000, 0, 4);
    push(3, d+14, 3'b000, 0, 4); push(4, d+21, 3'b000, 1, 5);
    push(1, d+22, 3'b000, 1, 5); push(2, d+26, 3'b000, 1, 5);
    push(3, d+30, 3'b000, 1, 5); push(4, d+34, 3'b000, 1, 6);
    // ignored strobes, IMU timeout colliding with err_clr
    push(1, d+42, 3'b000, 1, 6); push(2, d+50, 3'b001, 0, 6);
    push(3, d+54, 3'b001, 0, 6); push(4, d+58, 3'b001, 0, 7);
    // reset during LED, then restart
    push(1, d+62, 3'b001, 0, 7); push(2, d+66, 3'b001, 0, 7);
    push(3, d+70, 3'b001, 0, 7);
    push(1, d+73, 3'b000, 0, 0); push(2, d+77, 3'b000, 0, 0);

    enable = 1'b1;
    wait_to(b+26); enable = 1'b0;
    wait_to(b+34); chk("in_wait_after_tick", int'(state_dbg), 4);
    wait_to(b+42);
    chk("idle_after_disable", int'(state_dbg), 0);
    chk("busy_low_in_idle",   int'(busy),      0);

    wait_to(c); lat[1] = -1; enable = 1'b1;
    wait_to(c+14); lat[1] = 3;
    wait_to(c+22); err_clr = 1'b1;
    wait_to(c+23); err_clr = 1'b0;

    wait_to(c+34); for (int s = 0; s < 3; s++) lat[s] = 6;
    wait_to(d+21); for (int s = 0; s < 3; s++) lat[s] = 3;

    wait_to(d+35); lat[0] = 0;
    wait_to(d+43); chk("imu_done_in_start_ignored", int'(state_dbg), 1);
    wait_to(d+44); inj[2] = 1'b1;
    wait_to(d+45); inj[2] = 1'b0;
    chk("led_done_in_imu_ignored", int'(state_dbg), 1);
    wait_to(d+49); err_clr = 1'b1;
    wait_to(d+50); err_clr = 1'b0; lat[0] = 3;

    wait_to(d+71); rst_n = 1'b0; #1;
    chk_all_zero("async_rst");
    wait_to(d+72); rst_n = 1'b1; #1;
    chk("idle_after_release", int'(state_dbg), 0);

    wait_to(d+80);
    chk("all_events_seen", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
